// File: rtl/dmem_sized.sv
// dmem_sized -- byte-addressed data memory for the RV32 MEM stage.
//
// Requests use a valid/ready handshake. Every accepted request gets a
// one-cycle response pulse on the following cycle. Loads return the
// addressed byte, half or word, sign- or zero-extended to 32 bits. Stores
// write only the enabled byte lanes. A request that is misaligned or has an
// illegal size does not touch the array and is answered with misalign_err.
// After reset, an optional sequencer zeroes every word before the first
// request is accepted.
//
// Ports:
//   clk_dm        memory clock, rising edge
//   rst_dm        asynchronous active-high reset
//   req_valid     request present
//   req_ready     block accepts a request this cycle (registered)
//   Mem_Write     1 = store, 0 = load
//   Mem_Size      RISC-V funct3: 0 b, 1 h, 2 w, 4 bu, 5 hu
//   DM_Addr       byte address (word index = [ADDR_W-1:2], lane = [1:0])
//   M_W_Data      store data, right-aligned
//   rsp_valid     one-cycle pulse per accepted request
//   M_R_Data      load result (0 for stores and rejected requests)
//   misalign_err  qualifies rsp_valid: the request was rejected
module dmem_sized #(
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = $clog2(DEPTH) + 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_dm,
  input  logic              rst_dm,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              Mem_Write,
  input  logic [2:0]        Mem_Size,
  input  logic [ADDR_W-1:0] DM_Addr,
  input  logic [31:0]       M_W_Data,
  output logic              rsp_valid,
  output logic [31:0]       M_R_Data,
  output logic              misalign_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam state_t ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  // ------------------------------------------------------------------
  // Helper functions
  // ------------------------------------------------------------------

  // Size/alignment legality. Unsigned sizes exist only for loads.
  function automatic logic legal_f(input logic       wr,
                                   input logic [2:0] sz,
                                   input logic [1:0] lane);
    logic ok;
    case (sz)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~lane[0];
      SZ_W:    ok = (lane == 2'b00);
      SZ_BU:   ok = ~wr;
      SZ_HU:   ok = ~wr & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-lane enables for a store of the given size at the given lane.
  function automatic logic [3:0] lane_en_f(input logic [2:0] sz,
                                           input logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = 4'b0011 << lane;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across all lanes so that the lane
  // enables alone pick the bytes that land in the word.
  function automatic logic [31:0] wdata_f(input logic [2:0]  sz,
                                          input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Extract and extend the addressed byte/half from a stored word.
  function automatic logic [31:0] extract_f(input logic [2:0]  sz,
                                            input logic [1:0]  lane,
                                            input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (sz)
      SZ_B:    r = {{24{b[7]}}, b};
      SZ_BU:   r = {24'h000000, b};
      SZ_H:    r = {{16{h[15]}}, h};
      SZ_HU:   r = {16'h0000, h};
      SZ_W:    r = word;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  // ------------------------------------------------------------------
  // Storage and state
  // ------------------------------------------------------------------
  logic [31:0]      mem_r [DEPTH];
  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] clr_cnt_r;
  logic [IDX_W-1:0] clr_cnt_nxt_s;

  logic             req_ready_r;
  logic             rsp_valid_r;
  logic [31:0]      m_r_data_r;
  logic             misalign_err_r;

  logic [IDX_W-1:0] idx_s;
  logic [1:0]       lane_s;
  logic             accept_s;
  logic             legal_s;
  logic [31:0]      rd_word_s;

  logic             wr_en_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [3:0]       wr_be_s;
  logic [31:0]      wr_data_s;

  logic             req_ready_nxt_s;
  logic [31:0]      rsp_data_s;

  assign idx_s     = DM_Addr[ADDR_W-1:2];
  assign lane_s    = DM_Addr[1:0];
  assign accept_s  = req_valid & req_ready_r;
  assign legal_s   = legal_f(Mem_Write, Mem_Size, lane_s);
  // Combinational read of the current array: a store committed at the
  // previous edge is already visible to a load accepted at this edge.
  assign rd_word_s = mem_r[idx_s];

  assign req_ready    = req_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign M_R_Data     = m_r_data_r;
  assign misalign_err = misalign_err_r;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------

  // State and clear-counter register.
  always_ff @(posedge clk_dm or posedge rst_dm) begin
    if (rst_dm) begin
      state_r   <= ST_RESET;
      clr_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Next-state logic: CLEAR walks every word once, then IDLE forever.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = '0;
    case (state_r)
      ST_CLEAR: begin
        clr_cnt_nxt_s = clr_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
        if (clr_cnt_r == CNT_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_CLEAR;
      end
    endcase
  end

  // Output decode: ready follows the next state so it is itself a flop;
  // the response word is zero for stores and rejected requests.
  always_comb begin
    req_ready_nxt_s = 1'b0;
    rsp_data_s      = 32'h00000000;
    if (state_nxt_s == ST_IDLE) begin
      req_ready_nxt_s = 1'b1;
    end else begin
      req_ready_nxt_s = 1'b0;
    end
    if (legal_s && !Mem_Write) begin
      rsp_data_s = extract_f(Mem_Size, lane_s, rd_word_s);
    end else begin
      rsp_data_s = 32'h00000000;
    end
  end

  // Registered handshake and response outputs; data/err hold between pulses.
  always_ff @(posedge clk_dm or posedge rst_dm) begin
    if (rst_dm) begin
      req_ready_r    <= 1'b0;
      rsp_valid_r    <= 1'b0;
      m_r_data_r     <= 32'h00000000;
      misalign_err_r <= 1'b0;
    end else begin
      req_ready_r <= req_ready_nxt_s;
      rsp_valid_r <= accept_s;
      if (accept_s) begin
        m_r_data_r     <= rsp_data_s;
        misalign_err_r <= ~legal_s;
      end
    end
  end

  // ------------------------------------------------------------------
  // Array write port
  // ------------------------------------------------------------------

  // Write-port mux: the clear sequencer owns the port during CLEAR,
  // otherwise only accepted legal stores write.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = idx_s;
    wr_be_s   = 4'b0000;
    wr_data_s = 32'h00000000;
    if (state_r == ST_CLEAR) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = clr_cnt_r;
      wr_be_s   = 4'b1111;
      wr_data_s = 32'h00000000;
    end else if (accept_s && legal_s && Mem_Write) begin
      wr_en_s   = 1'b1;
      wr_idx_s  = idx_s;
      wr_be_s   = lane_en_f(Mem_Size, lane_s);
      wr_data_s = wdata_f(Mem_Size, M_W_Data);
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Byte-enabled array write; contents are deliberately not reset.
  always_ff @(posedge clk_dm) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be_s[i]) begin
          mem_r[wr_idx_s][i*8 +: 8] <= wr_data_s[i*8 +: 8];
        end
      end
    end
  end

endmodule
